// File: rtl/demux8_32_wr_pkg.sv
// demux8_32_wr_pkg: shared constants and types for the register-file datapath
package demux8_32_wr_pkg;
  localparam int WIDTH = 32;
  localparam int NREGS = 8;
  typedef enum logic {IDLE, CLEAR} state_t;
  typedef logic [2:0] idx_t;
endpackage

// File: rtl/demux8_32_wr_decoder3_8.sv
// decoder3_8: 3-bit index plus enable to 8-bit one-hot
module decoder3_8
  import demux8_32_wr_pkg::*;
(
  input  idx_t       idx,
  input  logic       en,
  output logic [7:0] onehot
);
  assign onehot = en ? (8'b1 << idx) : 8'b0;
endmodule

// File: rtl/demux8_32_wr.sv
// demux8_32_wr: 8x32 register bank with byte-masked write port and clear sweep
module demux8_32_wr
  import demux8_32_wr_pkg::*;
#(
  parameter int WIDTH = demux8_32_wr_pkg::WIDTH,
  parameter int NREGS = demux8_32_wr_pkg::NREGS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  idx_t               wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               clr_req,
  output logic               busy,
  output logic               wr_ack,
  output idx_t               wr_ack_addr,
  output logic [WIDTH-1:0]   q0,
  output logic [WIDTH-1:0]   q1,
  output logic [WIDTH-1:0]   q2,
  output logic [WIDTH-1:0]   q3,
  output logic [WIDTH-1:0]   q4,
  output logic [WIDTH-1:0]   q5,
  output logic [WIDTH-1:0]   q6,
  output logic [WIDTH-1:0]   q7
);
  state_t           state;
  idx_t             idx;
  logic             xfer;
  logic [7:0]       wr_sel;
  logic [7:0]       clr_sel;
  logic [WIDTH-1:0] bmask;
  logic [WIDTH-1:0] regs [NREGS];

  assign wr_ready = (state == IDLE);
  assign busy     = (state == CLEAR);
  assign xfer     = wr_valid && wr_ready;

  decoder3_8 u_wr_dec  (.idx(wr_addr), .en(xfer),  .onehot(wr_sel));
  decoder3_8 u_clr_dec (.idx(idx),     .en(busy),  .onehot(clr_sel));

  for (genvar b = 0; b < WIDTH/8; b++) begin : g_mask
    assign bmask[8*b +: 8] = {8{wr_be[b]}};
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    // sweep zeroing wins; writes never coincide with it since xfer needs IDLE
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs[r] <= '0;
      else if (clr_sel[r]) regs[r] <= '0;
      else if (wr_sel[r]) regs[r] <= (regs[r] & ~bmask) | (wr_data & bmask);
    end
  end

  // control FSM: sweep index wraps 7->0 exactly as the sweep exits to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else if (state == IDLE) begin
      if (clr_req) begin
        state <= CLEAR;
        idx   <= '0;
      end
    end else begin
      idx <= idx + 3'd1;
      if (idx == 3'd7) state <= IDLE;
    end
  end

  // acknowledge pulse; address holds between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack      <= 1'b0;
      wr_ack_addr <= '0;
    end else begin
      wr_ack <= xfer;
      if (xfer) wr_ack_addr <= wr_addr;
    end
  end

  assign q0 = regs[0];
  assign q1 = regs[1];
  assign q2 = regs[2];
  assign q3 = regs[3];
  assign q4 = regs[4];
  assign q5 = regs[5];
  assign q6 = regs[6];
  assign q7 = regs[7];
endmodule

// File: tb/tb_demux8_32_wr.sv
// tb_demux8_32_wr: vectors, corner sequences and randomized model checks
module tb_demux8_32_wr;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        clr_req = 1'b0;
  logic        busy;
  logic        wr_ack;
  logic [2:0]  wr_ack_addr;
  logic [31:0] q [8];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_q [8];
  int          m_cnt;
  logic        m_ack;
  logic [2:0]  m_ack_addr;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  demux8_32_wr dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .clr_req(clr_req),
    .busy(busy), .wr_ack(wr_ack), .wr_ack_addr(wr_ack_addr),
    .q0(q[0]), .q1(q[1]), .q2(q[2]), .q3(q[3]),
    .q4(q[4]), .q5(q[5]), .q6(q[6]), .q7(q[7])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_q[i] = '0;
    m_cnt = 0;
    m_ack = 1'b0;
    m_ack_addr = '0;
  endtask

  // m_cnt counts remaining sweep cycles; the zeroed register is 8-m_cnt
  task automatic model_edge();
    logic rdy;
    rdy = (m_cnt == 0);
    if (m_cnt > 0) begin
      m_q[8 - m_cnt] = '0;
      m_cnt--;
    end else if (clr_req) m_cnt = 8;
    if (wr_valid && rdy)
      for (int k = 0; k < 4; k++)
        if (wr_be[k]) m_q[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
    m_ack = wr_valid && rdy;
    if (m_ack) m_ack_addr = wr_addr;
  endtask

  task automatic check_all();
    for (int i = 0; i < 8; i++) chk($sformatf("q%0d", i), q[i], m_q[i]);
    chk("wr_ready", {31'b0, wr_ready}, {31'b0, m_cnt == 0});
    chk("busy", {31'b0, busy}, {31'b0, m_cnt != 0});
    chk("wr_ack", {31'b0, wr_ack}, {31'b0, m_ack});
    chk("wr_ack_addr", {29'b0, wr_ack_addr}, {29'b0, m_ack_addr});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_valid = 1'b0;
  endtask

  vec_t vecs [5];
  int   n;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_all();

    vecs[0] = '{3'd3, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    vecs[1] = '{3'd5, 32'h11223344, 4'hF, 32'h11223344};
    vecs[2] = '{3'd5, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD};
    vecs[3] = '{3'd5, 32'hFFFFFFFF, 4'b0000, 32'h11BB33DD};
    vecs[4] = '{3'd3, 32'h0000A500, 4'b0010, 32'hDEADA5EF};
    for (int i = 0; i < 5; i++) begin
      write(vecs[i].addr, vecs[i].data, vecs[i].be);
      chk($sformatf("vec%0d_q", i), q[vecs[i].addr], vecs[i].exp);
      chk($sformatf("vec%0d_ack", i), {31'b0, wr_ack}, 32'd1);
      chk($sformatf("vec%0d_ack_addr", i), {29'b0, wr_ack_addr}, {29'b0, vecs[i].addr});
    end

    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 32'(i) * 32'h01010101; wr_be = 4'hF;
      step();
      chk("b2b_ack", {31'b0, wr_ack}, 32'd1);
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 8; i++) chk("b2b_q", q[i], 32'(i) * 32'h01010101);

    for (int i = 0; i < 8; i++) write(3'(i), 32'hC0DE0000 | 32'(i + 1), 4'hF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 32'h55AA55AA; wr_be = 4'hF;
    n = 0;
    while (busy && n < 20) begin
      chk("sweep_ready", {31'b0, wr_ready}, 32'd0);
      n++;
      step();
    end
    chk("sweep_len", 32'(n), 32'd8);
    step();
    wr_valid = 1'b0;
    chk("held_ack", {31'b0, wr_ack}, 32'd1);
    chk("held_q2", q[2], 32'h55AA55AA);

    wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 32'h77777777; wr_be = 4'hF; clr_req = 1'b1;
    step();
    wr_valid = 1'b0; clr_req = 1'b0;
    chk("coin_ack_addr", {29'b0, wr_ack_addr}, 32'd7);
    chk("coin_q7", q[7], 32'h77777777);
    repeat (7) step();
    chk("coin_q7_kept", q[7], 32'h77777777);
    step();
    chk("coin_q7_zero", q[7], 32'h0);
    chk("coin_idle", {31'b0, wr_ready}, 32'd1);

    write(3'd6, 32'h66666666, 4'hF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, wr_ready}, 32'd1);
    chk("rst_q6", q[6], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    write(3'd4, 32'h44440000, 4'hC);
    chk("post_rst_ack", {31'b0, wr_ack}, 32'd1);
    chk("post_rst_q4", q[4], 32'h44440000);

    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = $urandom;
      wr_be = 4'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 24) == 0);
      step();
    end
    wr_valid = 1'b0; clr_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
